// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC register plus request/grant/response fetch FSM
//
// Holds the architectural PC, fetches one word per instruction from
// instruction memory and presents it to decode until the core commits it.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   npc, commit       next PC and single-cycle retire pulse from the core
//   pc                PC of the instruction being fetched or held
//   inst, inst_valid  fetched instruction word and its valid flag
//   imem_req          fetch request (combinational from state)
//   imem_addr         request address, always equal to pc
//   imem_gnt          memory accepts the request this cycle
//   imem_rvalid       response valid
//   imem_rdata        response instruction word
//   misalign          sticky: a committed npc was not word-aligned
//   fetch_cnt         completed fetch count, wraps modulo 2^32

module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        commit,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        misalign,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t state;
    state_t state_next;

    logic load_inst;
    logic load_pc;
    logic set_err;

    always_comb begin
        state_next = state;
        load_inst  = 1'b0;
        load_pc    = 1'b0;
        set_err    = 1'b0;
        imem_req   = 1'b0;
        case (state)
            S_REQ: begin
                // Gated by rst so no request leaks out while the memory is
                // itself being reset.
                imem_req = !rst;
                if (imem_gnt) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    load_inst  = 1'b1;
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    if (npc[1:0] == 2'b00) begin
                        load_pc    = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        set_err    = 1'b1;
                        state_next = S_ERR;
                    end
                end
            end
            S_ERR: begin
                // Terminal until reset: a bad target means the core has
                // lost control flow, so fetching anything further is wrong.
                state_next = S_ERR;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            inst       <= NOP;
            inst_valid <= 1'b0;
            misalign   <= 1'b0;
            fetch_cnt  <= 32'h0000_0000;
        end else begin
            state <= state_next;
            if (load_inst) begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
                fetch_cnt  <= fetch_cnt + 32'd1;
            end
            if (load_pc) begin
                pc         <= npc;
                inst_valid <= 1'b0;
            end
            if (set_err) begin
                // pc deliberately left pointing at the instruction whose
                // successor was misaligned.
                misalign   <= 1'b1;
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit with randomized memory timing

module tb_ifetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        commit;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        misalign;
    logic [31:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference state: what the architectural outputs must be.
    logic [31:0] model_pc;
    logic [31:0] model_cnt;
    logic [31:0] model_inst;

    ifetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .commit      (commit),
        .pc          (pc),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .misalign    (misalign),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every new instruction presented to decode is matched against
    // the next expected fetch.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (inst_valid === 1'b1 && prev_valid !== 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected actual=inst %h required=no fetch t=%0t", inst, $time);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e.pc);
                chk("sb_inst", inst, e.inst);
                chk("sb_cnt", fetch_cnt, e.cnt);
            end
        end
        prev_valid = inst_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        commit = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1 chk("rst_req", imem_req, 1'b0);
            @(negedge clk);
        end
        #1 chk("rst_req_last", imem_req, 1'b0);
        rst = 1'b0;
        model_pc = RESET_PC;
        model_cnt = 32'd0;
        model_inst = NOP;
        #1;
        chk("post_rst_req", imem_req, 1'b1);
        chk("post_rst_addr", imem_addr, RESET_PC);
        chk("post_rst_pc", pc, RESET_PC);
        chk("post_rst_valid", inst_valid, 1'b0);
        chk("post_rst_inst", inst, NOP);
        chk("post_rst_cnt", fetch_cnt, 32'd0);
        chk("post_rst_misalign", misalign, 1'b0);
    endtask

    // Act as instruction memory for one fetch; entered at a negedge in REQ,
    // returns at the negedge of the first HOLD cycle.
    task automatic fetch(input int gdly, input int k, input logic [31:0] data, input bit stray);
        exp_t e;
        for (int i = 0; i < gdly; i++) begin
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, model_pc);
            imem_gnt = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
        end
        chk("req", imem_req, 1'b1);
        chk("req_addr", imem_addr, model_pc);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        for (int i = 1; i <= k; i++) begin
            chk("wait_req", imem_req, 1'b0);
            chk("wait_valid", inst_valid, 1'b0);
            imem_rdata = $urandom;
            if (stray && i == 1) begin
                commit = 1'b1;
                npc = $urandom & 32'hFFFF_FFFC;
            end
            if (i == k) begin
                imem_rvalid = 1'b1;
                imem_rdata = data;
                model_cnt = model_cnt + 32'd1;
                model_inst = data;
                e.pc = model_pc;
                e.inst = data;
                e.cnt = model_cnt;
                exp_q.push_back(e);
            end
            @(negedge clk);
            commit = 1'b0;
            imem_rvalid = 1'b0;
            if (stray && i == 1) chk("stray_commit_pc", pc, model_pc);
        end
        chk("latency_valid", inst_valid, 1'b1);
        chk("hold_pc", pc, model_pc);
    endtask

    task automatic commit_to(input logic [31:0] target, input int hold);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", inst_valid, 1'b1);
            chk("hold_req", imem_req, 1'b0);
            imem_rvalid = 1'b1;
            imem_rdata = ~model_inst;
            @(negedge clk);
            imem_rvalid = 1'b0;
            chk("hold_inst", inst, model_inst);
            chk("hold_cnt", fetch_cnt, model_cnt);
        end
        commit = 1'b1;
        npc = target;
        @(negedge clk);
        commit = 1'b0;
        npc = $urandom;
        model_pc = target;
        chk("commit_pc", pc, target);
        chk("commit_addr", imem_addr, target);
        chk("commit_req", imem_req, 1'b1);
        chk("commit_valid", inst_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        npc = 32'd0;
        commit = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'd0;
        model_pc = RESET_PC;
        model_cnt = 32'd0;
        model_inst = NOP;
        @(negedge clk);

        do_reset(2);

        // Minimum-period fetch: immediate grant, k=1, commit in first HOLD cycle.
        fetch(0, 1, 32'h0050_0093, 1'b0);
        commit_to(32'h0000_0004, 0);

        // Stalled grant, k=4, stray commit during WAIT.
        fetch(3, 4, $urandom, 1'b1);
        commit_to($urandom & 32'hFFFF_FFFC, 1);

        for (int n = 0; n < 40; n++) begin
            fetch($urandom_range(0, 3), $urandom_range(1, 5), $urandom, ($urandom_range(0, 2) == 0));
            commit_to($urandom & 32'hFFFF_FFFC, $urandom_range(0, 2));
        end

        // Reset while a response arrives in WAIT: response must be lost.
        chk("pre_rst_pc_nonzero", (pc != RESET_PC) ? 32'd1 : 32'd0, (model_pc != RESET_PC) ? 32'd1 : 32'd0);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata = $urandom;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("rstwait_valid", inst_valid, 1'b0);
        chk("rstwait_pc", pc, RESET_PC);
        chk("rstwait_cnt", fetch_cnt, 32'd0);
        chk("rstwait_inst", inst, NOP);
        rst = 1'b0;
        model_pc = RESET_PC;
        model_cnt = 32'd0;
        model_inst = NOP;
        #1 chk("rstwait_req_after", imem_req, 1'b1);

        // Misaligned commit target.
        fetch(1, 2, $urandom, 1'b0);
        commit_to(32'h0000_0040, 0);
        fetch(0, 1, $urandom, 1'b0);
        commit = 1'b1;
        npc = 32'h0000_0102;
        @(negedge clk);
        commit = 1'b0;
        chk("mis_flag", misalign, 1'b1);
        chk("mis_pc", pc, model_pc);
        chk("mis_valid", inst_valid, 1'b0);
        chk("mis_req", imem_req, 1'b0);
        for (int i = 0; i < 12; i++) begin
            imem_gnt = 1'($urandom);
            imem_rvalid = 1'($urandom);
            imem_rdata = $urandom;
            commit = 1'($urandom);
            npc = $urandom & 32'hFFFF_FFFC;
            #1 chk("err_req", imem_req, 1'b0);
            @(negedge clk);
            chk("err_flag", misalign, 1'b1);
            chk("err_pc", pc, model_pc);
            chk("err_valid", inst_valid, 1'b0);
            chk("err_cnt", fetch_cnt, model_cnt);
        end
        commit = 1'b0;

        do_reset(1);

        // Counter wrap.
        force dut.fetch_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt;
        model_cnt = 32'hFFFF_FFFF;
        fetch(0, 2, $urandom, 1'b0);
        chk("wrap_cnt", fetch_cnt, 32'h0000_0000);
        commit_to(32'h0000_0008, 0);

        @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch front end for the RISC-V core. It holds the architectural PC register and issues word reads to instruction memory over a request/grant/response handshake. It presents each fetched instruction to the decode stage and loads the next PC, computed by the next-PC logic, when the core commits the current instruction. It replaces the bare PC flip-flop so that the core can run against instruction memory with variable latency.

## Interface
- RESET_PC, 32'h00000000, PC value loaded on reset; must be word-aligned.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- npc  input  32  next PC from the next-PC logic, valid while `commit` is high.
- commit  input  1  single-cycle pulse from the core: current instruction retired, load `npc`.
- pc  output  32  PC of the instruction currently being fetched or held.
- inst  output  32  fetched instruction word.
- inst_valid  output  1  `inst` is valid for `pc`.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  request address; always equals `pc`.
- imem_gnt  input  1  memory accepts the request in this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  response instruction word.
- misalign  output  1  sticky flag: a committed `npc` was not word-aligned.
- fetch_cnt  output  32  count of completed fetches; wraps modulo 2^32.

## Operation
- The FSM has four states: REQ, WAIT, HOLD and ERR. Reset enters REQ.
- **REQ**
  - `imem_req` = 1 and `imem_addr` = `pc`.
  - If `imem_gnt` = 1, go to WAIT. Otherwise stay in REQ, and keep `imem_req` and `imem_addr` stable.
- **WAIT**
  - `imem_req` = 0.
  - If `imem_rvalid` = 1, register `inst` <= `imem_rdata`, set `inst_valid` <= 1, increment `fetch_cnt`, and go to HOLD.
  - The wait lasts an unbounded number of cycles.
- **HOLD**
  - `inst_valid` = 1 and `inst` is stable.
  - On `commit` = 1 with `npc[1:0]` == 2'b00: `pc` <= `npc`, `inst_valid` <= 0, go to REQ.
  - On `commit` = 1 with `npc[1:0]` != 2'b00: `pc` is unchanged, `inst_valid` <= 0, `misalign` <= 1, go to ERR.
- **ERR**
  - No requests are issued, and `misalign` stays at 1.
  - The only exit is `rst`.
- `commit` in any state other than HOLD is ignored, so `pc` does not change.
- `imem_rvalid` in REQ, HOLD or ERR is ignored: no state or output change.
- Instruction memory shares `rst` and drops any outstanding response on reset. After reset the unit expects no stale `imem_rvalid`.
- PC arithmetic is owned by the next-PC logic. This block never increments `pc` itself.

## Timing
- **Reset values** (applied on the edge where `rst` = 1):
  - `pc` = RESET_PC
  - `inst` = 32'h00000013 (NOP)
  - `inst_valid` = 0
  - `misalign` = 0
  - `fetch_cnt` = 0
  - state = REQ
- `imem_req` and `imem_addr` are combinational from state and `pc`. `imem_req` is 0 while `rst` = 1 and goes high in the first cycle after `rst` falls.
- `imem_rvalid` may arrive no earlier than the cycle after the `imem_gnt` cycle.
- **Latency:** with `imem_gnt` in cycle t and `imem_rvalid` in cycle t+k (k ≥ 1), `inst_valid` is high from cycle t+k+1.
- **Commit:**
  - A commit in cycle c gives the new `pc` and `imem_req` = 1 in cycle c+1.
  - `inst_valid` is 0 in cycle c+1.
- Minimum instruction period is 3 cycles: REQ with immediate grant, WAIT with k = 1, and HOLD with commit in the first cycle.
- **Reset mid-operation:** `rst` asserted in any state, including WAIT with a response pending, gives the full reset values on the next edge. A response arriving in the reset cycle is discarded.

## Test plan
1. **Reset:** hold `rst` for 2 cycles with RESET_PC = 0.
   - During reset: `imem_req` = 0.
   - Cycle after release: `imem_req` = 1, `imem_addr` = 0, `inst_valid` = 0, `inst` = 0x00000013, `fetch_cnt` = 0.
2. **Zero-wait fetch:**
   - Stimulus: `imem_gnt` in the first cycle, `imem_rvalid` with `imem_rdata` = 0x00500093 in the next cycle, then `commit` with `npc` = 0x4 in the first HOLD cycle.
   - Expected: `inst_valid` = 1 with `inst` = 0x00500093 two cycles after the grant, and `fetch_cnt` = 1. After commit, `pc` = 0x4 and `imem_addr` = 0x4.
3. **Stalled grant and response:**
   - Stimulus: `imem_gnt` low for 3 cycles, then response latency k = 4.
   - Expected: `imem_req` and `imem_addr` stay stable through the stall. `inst_valid` rises exactly 5 cycles after the grant. A stray `commit` during WAIT leaves `pc` unchanged.
4. **Misaligned target:** `commit` with `npc` = 0x00000102.
   - Expected next cycle: `misalign` = 1, `pc` unchanged, `inst_valid` = 0.
   - Expected afterwards: `imem_req` stays 0 for 10+ cycles until `rst`.
5. **Reset during WAIT:** assert `rst` in a WAIT cycle while `imem_rvalid` = 1.
   - Expected: `inst_valid` = 0, `pc` = RESET_PC, `fetch_cnt` not incremented.
   - Then `imem_req` = 1 after release.
6. **Counter wrap:** force `fetch_cnt` to 0xFFFFFFFF, then complete one fetch.
   - Expected: `fetch_cnt` = 0x00000000.
